// File: rtl/alu_input_sequencer.sv
// rtl/alu_input_sequencer.sv - switch/button front end that sequences opcode, source and destination loads into ALU_wrapper
module alu_input_sequencer #(
    parameter int DB_CYCLES     = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic [9:0]  data_in,
    output logic [9:0]  data_out,
    output logic        ld_op_code,
    output logic        ld_src,
    output logic        ld_dest,
    input  logic [15:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic [15:0] result,
    output logic [4:0]  flags,
    output logic        result_valid,
    output logic [1:0]  phase
);

    localparam logic [15:0] DB_LIMIT     = 16'(DB_CYCLES);
    localparam logic [3:0]  SETTLE_LIMIT = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_OP,
        S_SRC,
        S_DEST,
        S_EXEC,
        S_DONE
    } state_t;

    state_t      state;
    logic        step_meta;
    logic        step_sync;
    logic        db_level;
    logic        db_prev;
    logic [15:0] db_count;
    logic [3:0]  settle_count;
    logic        step_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
        end
    end

    // The debounced level only moves after the synchronised level has
    // disagreed with it for DB_CYCLES + 1 consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_count <= '0;
        end else begin
            db_prev <= db_level;
            if (step_sync == db_level) begin
                db_count <= '0;
            end else if (db_count == DB_LIMIT) begin
                db_level <= ~db_level;
                db_count <= '0;
            end else begin
                db_count <= db_count + 16'd1;
            end
        end
    end

    assign step_pulse = db_level & ~db_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_OP;
            data_out     <= '0;
            ld_op_code   <= 1'b0;
            ld_src       <= 1'b0;
            ld_dest      <= 1'b0;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
            phase        <= 2'd0;
            settle_count <= '0;
        end else begin
            ld_op_code <= 1'b0;
            ld_src     <= 1'b0;
            ld_dest    <= 1'b0;
            case (state)
                S_OP: begin
                    if (step_pulse) begin
                        data_out   <= data_in;
                        ld_op_code <= 1'b1;
                        state      <= S_SRC;
                        phase      <= 2'd1;
                    end
                end
                S_SRC: begin
                    if (step_pulse) begin
                        data_out <= data_in;
                        ld_src   <= 1'b1;
                        state    <= S_DEST;
                        phase    <= 2'd2;
                    end
                end
                S_DEST: begin
                    if (step_pulse) begin
                        data_out     <= data_in;
                        ld_dest      <= 1'b1;
                        state        <= S_EXEC;
                        phase        <= 2'd3;
                        settle_count <= '0;
                    end
                end
                // Presses arriving while the ALU settles are dropped on purpose.
                S_EXEC: begin
                    if (settle_count == SETTLE_LIMIT) begin
                        result       <= alu_out;
                        flags        <= alu_flags;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        settle_count <= settle_count + 4'd1;
                    end
                end
                S_DONE: begin
                    if (step_pulse) begin
                        result_valid <= 1'b0;
                        data_out     <= data_in;
                        ld_op_code   <= 1'b1;
                        state        <= S_SRC;
                        phase        <= 2'd1;
                    end
                end
                default: begin
                    state <= S_OP;
                    phase <= 2'd0;
                end
            endcase
        end
    end

endmodule
